// File: rtl/hack_pkg.sv
// Shared definitions for the Hack execution core: FSM state encoding,
// instruction-word field positions and a small decode helper.
package hack_pkg;

    // Three-state instruction sequencer, cycled unconditionally
    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        DECODE = 2'd1,
        EXEC   = 2'd2
    } state_t;

    // Instruction word field positions
    localparam int C_BIT    = 15;
    localparam int A_BIT    = 12;
    localparam int COMP_MSB = 11;
    localparam int COMP_LSB = 6;
    localparam int DEST_A   = 5;
    localparam int DEST_D   = 4;
    localparam int DEST_M   = 3;
    localparam int JMP_LT   = 2;
    localparam int JMP_EQ   = 1;
    localparam int JMP_GT   = 0;

    // Bit 15 set marks a compute (C) instruction, clear marks a load-A instruction
    function automatic logic isCInstr(input logic [15:0] ir);
        return ir[C_BIT];
    endfunction

endpackage

// File: rtl/hack_alu.sv
// Standard Hack ALU: optional zero/negate on each operand, add or AND,
// optional negate of the result, plus zero and negative flags.
module hack_alu (
    input  logic [15:0] x_i,
    input  logic [15:0] y_i,
    input  logic        zx_i,
    input  logic        nx_i,
    input  logic        zy_i,
    input  logic        ny_i,
    input  logic        f_i,
    input  logic        no_i,
    output logic [15:0] out_o,
    output logic        zr_o,
    output logic        ng_o
);

    logic [15:0] xz;
    logic [15:0] xn;
    logic [15:0] yz;
    logic [15:0] yn;
    logic [15:0] fOut;

    // Operand conditioning, function select and output negation
    always_comb begin
        xz    = zx_i ? 16'h0000 : x_i;
        xn    = nx_i ? ~xz : xz;
        yz    = zy_i ? 16'h0000 : y_i;
        yn    = ny_i ? ~yz : yz;
        fOut  = f_i ? (xn + yn) : (xn & yn);
        out_o = no_i ? ~fOut : fOut;
        zr_o  = (out_o == 16'h0000);
        ng_o  = out_o[15];
    end

endmodule

// File: rtl/hack_jump_unit.sv
// Jump decision for a C-instruction from its three jump bits and the
// ALU's negative and zero flags.
module hack_jump_unit
    import hack_pkg::*;
(
    input  logic [2:0] jmp_i,
    input  logic       zr_i,
    input  logic       ng_i,
    output logic       jump_o
);

    // Less-than, equal and greater-than conditions OR together
    always_comb begin
        jump_o = (jmp_i[JMP_LT] & ng_i)
               | (jmp_i[JMP_EQ] & zr_i)
               | (jmp_i[JMP_GT] & ~ng_i & ~zr_i);
    end

endmodule

// File: rtl/hack_cpu.sv
// Multi-cycle Hack core: FETCH -> DECODE -> EXEC, owning A, D, PC and IR.
// Talks to a synchronous instruction ROM and data RAM (one-cycle read
// latency) and commits ALU results at the end of EXEC.
// Optional build macro HACK_CPU_DEBUG_EN adds dbg_* register mirrors.
module hack_cpu
    import hack_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    output logic [14:0] rom_addr,
    input  logic [15:0] rom_data,
    output logic [14:0] ram_addr,
    input  logic [15:0] ram_rdata,
    output logic [15:0] ram_wdata,
    output logic        ram_we,
    output logic        retire
`ifdef HACK_CPU_DEBUG_EN
    ,
    output logic [15:0] dbg_a,
    output logic [15:0] dbg_d,
    output logic [15:0] dbg_ir,
    output logic [1:0]  dbg_state
`endif
);

    state_t      state_q, state_d;
    logic [15:0] ir_q, ir_d;
    logic [15:0] a_q, a_d;
    logic [15:0] d_q, d_d;
    logic [14:0] pc_q, pc_d;

    logic [15:0] aluY;
    logic [15:0] aluOut;
    logic        aluZr;
    logic        aluNg;
    logic        jumpTaken;
    logic        isC;
    logic        writeM;

    assign isC      = isCInstr(ir_q);
    assign rom_addr = pc_q;
    assign ram_addr = a_q[14:0];
    assign aluY     = ir_q[A_BIT] ? ram_rdata : a_q;

    hack_alu uAlu (
        .x_i   (d_q),
        .y_i   (aluY),
        .zx_i  (ir_q[COMP_MSB]),
        .nx_i  (ir_q[COMP_MSB-1]),
        .zy_i  (ir_q[COMP_MSB-2]),
        .ny_i  (ir_q[COMP_MSB-3]),
        .f_i   (ir_q[COMP_MSB-4]),
        .no_i  (ir_q[COMP_LSB]),
        .out_o (aluOut),
        .zr_o  (aluZr),
        .ng_o  (aluNg)
    );

    hack_jump_unit uJump (
        .jmp_i  (ir_q[2:0]),
        .zr_i   (aluZr),
        .ng_i   (aluNg),
        .jump_o (jumpTaken)
    );

    // State and architectural registers; reset clears everything at once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
            ir_q    <= 16'h0000;
            a_q     <= 16'h0000;
            d_q     <= 16'h0000;
            pc_q    <= 15'h0000;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            d_q     <= d_d;
            pc_q    <= pc_d;
        end
    end

    // Sequencer next state and the EXEC-only strobes for memory and retire
    always_comb begin
        state_d   = state_q;
        writeM    = 1'b0;
        retire    = 1'b0;
        ram_we    = 1'b0;
        ram_wdata = 16'h0000;
        case (state_q)
            FETCH:   state_d = DECODE;
            DECODE:  state_d = EXEC;
            EXEC: begin
                state_d   = FETCH;
                retire    = 1'b1;
                writeM    = isC & ir_q[DEST_M];
                ram_we    = writeM;
                ram_wdata = writeM ? aluOut : 16'h0000;
            end
            default: state_d = FETCH;
        endcase
    end

    // Register commit: IR at end of DECODE, A/D/PC at end of EXEC. Jump
    // target and write address both come from the A value held during EXEC.
    always_comb begin
        ir_d = ir_q;
        a_d  = a_q;
        d_d  = d_q;
        pc_d = pc_q;
        if (state_q == DECODE) begin
            ir_d = rom_data;
        end
        if (state_q == EXEC) begin
            if (!isC) begin
                a_d  = {1'b0, ir_q[14:0]};
                pc_d = pc_q + 15'd1;
            end else begin
                if (ir_q[DEST_A]) begin
                    a_d = aluOut;
                end
                if (ir_q[DEST_D]) begin
                    d_d = aluOut;
                end
                pc_d = jumpTaken ? a_q[14:0] : (pc_q + 15'd1);
            end
        end
    end

`ifdef HACK_CPU_DEBUG_EN
    assign dbg_a     = a_q;
    assign dbg_d     = d_q;
    assign dbg_ir    = ir_q;
    assign dbg_state = state_q;
`endif

endmodule
